// File: rtl/uut_test_pkg.sv
// Shared types for the UUT test sequencer.
//   seq_state_t  : sequencer FSM states (visible on debug word 0)
//   DBG_*        : debug_sel encodings
//   res_flags_t  : status part of a result record
//   sat_inc32    : saturating 32-bit increment for the timeout counter
// The full result record {data, cycles, flags} depends on the OUT_WIDTH and
// CYC_WIDTH parameters, so it is declared as uut_res_rec_t inside
// uut_test_sequencer and embeds res_flags_t from here.
package uut_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VEC = 3'd1,
    ST_RST_UUT  = 3'd2,
    ST_RUN      = 3'd3,
    ST_RESULT   = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

  localparam logic [1:0] DBG_STATUS   = 2'd0;  // {state, vec_count}
  localparam logic [1:0] DBG_CYCLES   = 2'd1;  // res_cycles[31:0]
  localparam logic [1:0] DBG_DATA     = 2'd2;  // res_data[31:0]
  localparam logic [1:0] DBG_TIMEOUTS = 2'd3;  // timeouts this session

  typedef struct packed {
    logic timeout;
    logic mismatch;
    logic last;
  } res_flags_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/uut_run_timer.sv
// Run-length timer for one UUT run.
//   clk, rst : clock, asynchronous active-high reset
//   load     : preset count to 1 (held while the UUT is not running, so the
//              first RUN cycle already reads 1)
//   en       : count this cycle (UUT running)
//   count    : current run cycle number, stops at TIMEOUT_CYCLES
//   timeout  : count has reached TIMEOUT_CYCLES
module uut_run_timer #(
  parameter int CYC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  output logic [CYC_WIDTH-1:0] count,
  output logic                 timeout
);

  localparam logic [CYC_WIDTH-1:0] LIMIT = CYC_WIDTH'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CYC_WIDTH'(1);
    end else if (load) begin
      count <= CYC_WIDTH'(1);
    end else if (en && !timeout) begin
      count <= count + CYC_WIDTH'(1);
    end
  end

  assign timeout = (count == LIMIT);

endmodule

// File: rtl/uut_test_sequencer.sv
// Test-vector sequencer for a UUT with a rst/end handshake.
// Pulls packed vectors from the loader, holds the UUT in reset, runs it until
// end_uut or TIMEOUT_CYCLES, and emits one result record per vector.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle pulse, opens a session from IDLE
//   vec_valid/vec_ready       vector stream (vec_data, vec_last)
//   rst_uut, input_to_uut     UUT reset and registered UUT input
//   end_uut, output_from_uut  UUT completion level and result
//   res_valid/res_ready       result stream (res_data, res_cycles,
//                             res_timeout, res_mismatch, res_last)
//   busy, done, vec_count     session status
//   debug_sel, debug          debug word mux (state visible on word 0)
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never drops before its transfer and the payload is
// stable while valid is high. vec_ready and res_valid decode the registered
// state only, so there is no combinational path from ready to valid.
// Build option: define UUT_REPEAT_CHECK_EN to run every vector twice and flag
// disagreement between the two runs in res_mismatch.
module uut_test_sequencer
  import uut_test_pkg::*;
#(
  parameter int IN_WIDTH       = 128,
  parameter int OUT_WIDTH      = 128,
  parameter int CYC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RST_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [IN_WIDTH-1:0]  vec_data,
  input  logic                 vec_last,
  output logic                 rst_uut,
  output logic [IN_WIDTH-1:0]  input_to_uut,
  input  logic                 end_uut,
  input  logic [OUT_WIDTH-1:0] output_from_uut,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [CYC_WIDTH-1:0] res_cycles,
  output logic                 res_timeout,
  output logic                 res_mismatch,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count,
  input  logic [1:0]           debug_sel,
  output logic [31:0]          debug
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [CYC_WIDTH-1:0] cycles;
    res_flags_t           flags;
  } uut_res_rec_t;

  seq_state_t           state, state_nxt;
  logic [RCW-1:0]       rst_cnt;
  logic                 last_q;
  uut_res_rec_t         rec;
  logic [31:0]          timeout_cnt;
  logic [CYC_WIDTH-1:0] run_count;
  logic                 run_timeout;
  logic                 vec_hs;
  logic                 res_hs;
  logic                 run_end;
  logic                 final_run;

`ifdef UUT_REPEAT_CHECK_EN
  logic                 second_run;
  logic [OUT_WIDTH-1:0] first_data;
  logic                 first_to;
  assign final_run = second_run;
`else
  assign final_run = 1'b1;
`endif

  assign vec_hs  = vec_valid && (state == ST_WAIT_VEC);
  assign res_hs  = res_ready && (state == ST_RESULT);
  // end_uut in the timeout cycle still counts as a normal finish.
  assign run_end = (state == ST_RUN) && (end_uut || run_timeout);

  uut_run_timer #(
    .CYC_WIDTH      (CYC_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state != ST_RUN),
    .en      (state == ST_RUN),
    .count   (run_count),
    .timeout (run_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start)          state_nxt = ST_WAIT_VEC;
      ST_WAIT_VEC: if (vec_hs)         state_nxt = ST_RST_UUT;
      ST_RST_UUT:  if (rst_cnt == '0)  state_nxt = ST_RUN;
      ST_RUN:      if (run_end)        state_nxt = final_run ? ST_RESULT : ST_RST_UUT;
      ST_RESULT:   if (res_hs)         state_nxt = last_q ? ST_DONE : ST_WAIT_VEC;
      ST_DONE:                         state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt      <= '0;
      last_q       <= 1'b0;
      rec          <= '0;
      timeout_cnt  <= '0;
      vec_count    <= '0;
      input_to_uut <= '0;
`ifdef UUT_REPEAT_CHECK_EN
      second_run   <= 1'b0;
      first_data   <= '0;
      first_to     <= 1'b0;
`endif
    end else begin
      if ((state == ST_IDLE) && start) begin
        vec_count   <= '0;
        timeout_cnt <= '0;
      end

      if (vec_hs) begin
        input_to_uut <= vec_data;
        last_q       <= vec_last;
        rst_cnt      <= RCW'(RST_CYCLES - 1);
`ifdef UUT_REPEAT_CHECK_EN
        second_run   <= 1'b0;
`endif
      end

      if ((state == ST_RST_UUT) && (rst_cnt != '0)) begin
        rst_cnt <= rst_cnt - RCW'(1);
      end

      if (run_end) begin
        if (!end_uut) timeout_cnt <= sat_inc32(timeout_cnt);
`ifdef UUT_REPEAT_CHECK_EN
        if (!second_run) begin
          first_data <= end_uut ? output_from_uut : '0;
          first_to   <= !end_uut;
          second_run <= 1'b1;
          rst_cnt    <= RCW'(RST_CYCLES - 1);
        end else begin
          rec.data           <= end_uut ? output_from_uut : '0;
          rec.cycles         <= run_count;
          rec.flags.timeout  <= !end_uut;
          rec.flags.mismatch <= first_to || !end_uut || (first_data != output_from_uut);
          rec.flags.last     <= last_q;
        end
`else
        rec.data           <= end_uut ? output_from_uut : '0;
        // On a timeout run_count has stopped at TIMEOUT_CYCLES.
        rec.cycles         <= run_count;
        rec.flags.timeout  <= !end_uut;
        rec.flags.mismatch <= 1'b0;
        rec.flags.last     <= last_q;
`endif
      end

      if (res_hs) vec_count <= vec_count + 16'd1;
    end
  end

  // The UUT stays out of reset through RESULT so its output remains
  // observable until the record is taken.
  assign rst_uut      = !((state == ST_RUN) || (state == ST_RESULT));
  assign vec_ready    = (state == ST_WAIT_VEC);
  assign res_valid    = (state == ST_RESULT);
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign res_data     = rec.data;
  assign res_cycles   = rec.cycles;
  assign res_timeout  = rec.flags.timeout;
  assign res_mismatch = rec.flags.mismatch;
  assign res_last     = rec.flags.last;

  always_comb begin
    debug = '0;
    case (debug_sel)
      DBG_STATUS:   debug = {13'd0, state, vec_count};
      DBG_CYCLES:   debug = 32'(rec.cycles);
      DBG_DATA:     debug = 32'(rec.data);
      DBG_TIMEOUTS: debug = timeout_cnt;
      default:      debug = '0;
    endcase
  end

endmodule

// File: tb/tb_uut_test_sequencer.sv
// Bench for uut_test_sequencer: a toy UUT, vector/result drivers, a
// record-level reference model feeding an expected queue, and a per-cycle
// compare process. Vector encoding used by the toy UUT:
//   vec_data[19:0]  = cycle on which end_uut rises (0 = never)
//   vec_data[63:32] = value reported on output_from_uut
module tb_uut_test_sequencer;

  localparam int IW = 128;
  localparam int OW = 128;
  localparam int CW = 32;
  localparam int TO = 100;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          vec_valid;
  logic          vec_ready;
  logic [IW-1:0] vec_data;
  logic          vec_last;
  logic          rst_uut;
  logic [IW-1:0] input_to_uut;
  logic          end_uut;
  logic [OW-1:0] output_from_uut;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [OW-1:0] res_data;
  logic [CW-1:0] res_cycles;
  logic          res_timeout;
  logic          res_mismatch;
  logic          res_last;
  logic          busy;
  logic          done;
  logic [15:0]   vec_count;
  logic [1:0]    debug_sel;
  logic [31:0]   debug;

  always #5 clk = ~clk;

  uut_test_sequencer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .CYC_WIDTH(CW),
    .TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_last(vec_last),
    .rst_uut(rst_uut), .input_to_uut(input_to_uut),
    .end_uut(end_uut), .output_from_uut(output_from_uut),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cycles(res_cycles), .res_timeout(res_timeout), .res_mismatch(res_mismatch),
    .res_last(res_last), .busy(busy), .done(done), .vec_count(vec_count),
    .debug_sel(debug_sel), .debug(debug)
  );

  // ---------------- toy UUT ----------------
  logic [31:0] run_cyc = '0;
  logic [1:0]  run_idx = '0;   // runs started for the current vector
  logic        armed   = 1'b1;
  logic        flaky   = 1'b0; // output differs between runs of one vector
  logic [19:0] uut_n;

  assign uut_n           = input_to_uut[19:0];
  assign end_uut         = !rst_uut && (uut_n != 20'd0) && ((run_cyc + 32'd1) >= {12'd0, uut_n});
  assign output_from_uut = {96'd0, input_to_uut[63:32] ^ (flaky ? {30'd0, run_idx} : 32'd0)};

  always @(posedge clk) begin
    run_cyc <= rst_uut ? 32'd0 : run_cyc + 32'd1;
    if (vec_valid && vec_ready) run_idx <= 2'd0;
    else if (!rst_uut && armed) run_idx <= run_idx + 2'd1;
    armed <= rst_uut;
  end

  // ---------------- result-side stall driver ----------------
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (res_valid && stall_left > 0) begin
      res_ready = 1'b0;
      stall_left--;
    end else begin
      res_ready = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] cycles;
    logic          timeout;
    logic          mismatch;
    logic          last;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record the sequencer must produce for one vector, from the run rules.
  function automatic rec_t model_rec(input int n, input logic [31:0] out,
                                     input logic last, input logic fl);
    rec_t r;
    logic ends;
    ends       = (n != 0) && (n <= TO);
    r.data     = ends ? {96'd0, out} : '0;
    r.cycles   = ends ? CW'(n) : CW'(TO);
    r.timeout  = !ends;
    r.mismatch = 1'b0;
    r.last     = last;
`ifdef UUT_REPEAT_CHECK_EN
    // The reported run is the second one; the flaky UUT reports out^2 there.
    if (ends && fl) r.data = {96'd0, out ^ 32'd2};
    r.mismatch = !ends || fl;
`else
    if (fl) r.mismatch = 1'b0;
`endif
    return r;
  endfunction

  // ---------------- compare process ----------------
  int            cyc = 0;
  int            acc_cyc = 0;
  logic [IW-1:0] acc_data = '0;
  bit            pend = 0;
  bit            hold = 0;
  rec_t          held;
  int            stall_seen = 0;
  int            done_cnt = 0;
  int            n_rec = 0;

  always @(negedge clk) begin
    rec_t e;
    cyc++;
    if (rst) begin
      hold = 0;
      pend = 0;
    end else begin
      if (vec_valid && vec_ready) begin
        pend     = 1;
        acc_cyc  = cyc;
        acc_data = vec_data;
      end else if (pend && !rst_uut) begin
        check("run_start_latency", 128'(cyc - acc_cyc), 128'(RC + 1));
        check("input_to_uut", input_to_uut, acc_data);
        pend = 0;
      end
      if (res_valid) check("vec_ready_during_result", {127'd0, vec_ready}, 128'd0);
      if (hold) begin
        check("stall_valid", {127'd0, res_valid}, 128'd1);
        check("stall_data", res_data, held.data);
        check("stall_cycles", 128'(res_cycles), 128'(held.cycles));
        check("stall_flags", {125'd0, res_timeout, res_mismatch, res_last},
              {125'd0, held.timeout, held.mismatch, held.last});
      end
      hold = res_valid && !res_ready;
      if (hold) begin
        stall_seen++;
        held = '{res_data, res_cycles, res_timeout, res_mismatch, res_last};
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_cycles", 128'(res_cycles), 128'(e.cycles));
          check("res_timeout", {127'd0, res_timeout}, {127'd0, e.timeout});
          check("res_mismatch", {127'd0, res_mismatch}, {127'd0, e.mismatch});
          check("res_last", {127'd0, res_last}, {127'd0, e.last});
          n_rec++;
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", {127'd0, busy}, 128'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("vec_count_after_start", 128'(vec_count), 128'd0);
    debug_sel = 2'd3; #1;
    check("timeouts_after_start", 128'(debug), 128'd0);
  endtask

  task automatic send_vec(input int n, input logic [31:0] out, input logic last, input logic fl);
    bit got = 0;
    exp_q.push_back(model_rec(n, out, last, fl));
    vec_data  = {64'd0, out, 12'd0, n[19:0]};
    vec_last  = last;
    vec_valid = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (vec_ready) got = 1;
    end
    if (!got) begin
      check("vec_accept_timeout", 128'd1, 128'd0);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", {127'd0, seen}, 128'd1);
    @(negedge clk); #1;
  endtask

  task automatic read_debug(input string name, input logic [1:0] sel, input logic [31:0] exp);
    debug_sel = sel; #1;
    check(name, 128'(debug), 128'(exp));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit in_run;
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_data = '0; vec_last = 1'b0;
    debug_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rst_uut", {127'd0, rst_uut}, 128'd1);
    check("reset_vec_ready", {127'd0, vec_ready}, 128'd0);
    check("reset_res_valid", {127'd0, res_valid}, 128'd0);
    check("reset_res_fields", {res_data, res_timeout, res_mismatch, res_last}, 128'd0);
    check("reset_res_cycles", 128'(res_cycles), 128'd0);
    check("reset_input_to_uut", input_to_uut, 128'd0);
    check("reset_busy_done", {126'd0, busy, done}, 128'd0);
    check("reset_vec_count", 128'(vec_count), 128'd0);
    for (int s = 0; s < 4; s++) read_debug("reset_debug", 2'(s), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single vector, UUT ends on cycle 70.
    done_cnt = 0;
    pulse_start();
    send_vec(70, 32'hDEADBEEF, 1'b1, 1'b0);
    wait_done(400);
    check("t1_done_pulses", 128'(done_cnt), 128'd1);
    check("t1_vec_count", 128'(vec_count), 128'd1);
    check("t1_idle", {126'd0, busy, done}, 128'd0);
    read_debug("t1_dbg_cycles", 2'd1, 32'd70);
    read_debug("t1_dbg_data", 2'd2, 32'hDEADBEEF);
    read_debug("t1_dbg_status", 2'd0, 32'h0000_0001);

    // Three vectors, record 2 held for 10 cycles.
    done_cnt = 0;
    stall_seen = 0;
    pulse_start();
    send_vec(10, 32'h1111_1111, 1'b0, 1'b0);
    send_vec(20, 32'h2222_2222, 1'b0, 1'b0);
    stall_left = 10;
    send_vec(30, 32'h3333_3333, 1'b1, 1'b0);
    wait_done(600);
    check("t2_vec_count", 128'(vec_count), 128'd3);
    check("t2_done_pulses", 128'(done_cnt), 128'd1);
    check("t2_stall_len", 128'(stall_seen), 128'd10);

    // UUT never ends.
    pulse_start();
    send_vec(0, 32'hAAAA_5555, 1'b1, 1'b0);
    wait_done(600);
`ifdef UUT_REPEAT_CHECK_EN
    read_debug("t3_dbg_timeouts", 2'd3, 32'd2);
`else
    read_debug("t3_dbg_timeouts", 2'd3, 32'd1);
`endif
    read_debug("t3_dbg_cycles", 2'd1, 32'd100);
    read_debug("t3_dbg_data", 2'd2, 32'd0);

    // end_uut on the first RUN cycle, then coincident with the timeout.
    pulse_start();
    send_vec(1, 32'h0101_0101, 1'b0, 1'b0);
    send_vec(100, 32'h0BAD_F00D, 1'b1, 1'b0);
    wait_done(800);
    read_debug("t4_dbg_timeouts", 2'd3, 32'd0);
    read_debug("t4_dbg_cycles", 2'd1, 32'd100);
    read_debug("t4_dbg_data", 2'd2, 32'h0BAD_F00D);

    // Reset during the run of vector 2, then a clean new session.
    pulse_start();
    send_vec(5, 32'h5555_0005, 1'b0, 1'b0);
    send_vec(80, 32'h8080_8080, 1'b1, 1'b0);
    in_run = 0;
    for (int i = 0; i < 400 && !in_run; i++) begin
      @(negedge clk);
      if (!rst_uut && vec_count == 16'd1) in_run = 1;
    end
    check("t5_reached_run", {127'd0, in_run}, 128'd1);
    repeat (3) @(negedge clk);
    debug_sel = 2'd1;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_uut", {127'd0, rst_uut}, 128'd1);
    check("t5_handshakes", {126'd0, vec_ready, res_valid}, 128'd0);
    check("t5_res_fields", {res_data, res_timeout, res_mismatch, res_last}, 128'd0);
    check("t5_res_cycles", 128'(res_cycles), 128'd0);
    check("t5_input_to_uut", input_to_uut, 128'd0);
    check("t5_busy_done", {126'd0, busy, done}, 128'd0);
    check("t5_vec_count", 128'(vec_count), 128'd0);
    check("t5_dbg_cycles", 128'(debug), 128'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    done_cnt = 0;
    pulse_start();
    send_vec(7, 32'h0000_0777, 1'b1, 1'b0);
    wait_done(400);
    check("t5_vec_count_after", 128'(vec_count), 128'd1);
    check("t5_done_pulses", 128'(done_cnt), 128'd1);

`ifdef UUT_REPEAT_CHECK_EN
    // Inconsistent UUT, then a consistent one.
    flaky = 1'b1;
    pulse_start();
    send_vec(40, 32'h1234_5678, 1'b1, 1'b1);
    wait_done(600);
    flaky = 1'b0;
    pulse_start();
    send_vec(40, 32'h1234_5678, 1'b1, 1'b0);
    wait_done(600);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    check("records_seen", 128'(n_rec), 128'(n_rec > 0 ? n_rec : -1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uut_test_sequencer.md
Name: uut_test_sequencer

Overview:
Parametrised successor to the single-shot autotest UUT driver. Consumes a stream of packed test vectors and runs each one through the UUT:
- hold the UUT in reset, release it, then time the run until end_uut or a timeout;
- capture the UUT output, emit one result record per vector.
Sits between the SD-card vector loader/result writer and any UUT with a rst/end handshake (e.g. the KDF_spongent core).

Parameters:
IN_WIDTH, 128, packed UUT input width (salt|password|count concatenated by the loader)
OUT_WIDTH, 128, UUT output width
CYC_WIDTH, 32, cycle-counter width
TIMEOUT_CYCLES, 1000000, max run cycles before timeout; must be >= 1 and < 2**CYC_WIDTH
RST_CYCLES, 4, cycles rst_uut is held high before each run; >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a test session when IDLE
vec_valid  in  1  input vector available
vec_ready  out  1  sequencer accepts vector
vec_data  in  IN_WIDTH  packed UUT input vector
vec_last  in  1  marks final vector of session
rst_uut  out  1  UUT reset, active high
input_to_uut  out  IN_WIDTH  registered UUT input
end_uut  in  1  UUT completion flag, level
output_from_uut  in  OUT_WIDTH  UUT result
res_valid  out  1  result record valid
res_ready  in  1  downstream accepts result
res_data  out  OUT_WIDTH  captured UUT output (0 on timeout)
res_cycles  out  CYC_WIDTH  run length in cycles
res_timeout  out  1  run hit TIMEOUT_CYCLES
res_mismatch  out  1  repeat-run disagreement (see Optional Feature)
res_last  out  1  copy of vec_last for this record
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end
vec_count  out  16  vectors completed this session, wraps at 65535->0
debug_sel  in  2  selects debug word
debug  out  32  0: {state,vec_count}; 1: res_cycles[31:0]; 2: res_data[31:0]; 3: timeout count

Behaviour:
- Asynchronous reset: state IDLE, rst_uut=1, vec_ready=0, res_valid=0, all res_* fields=0, input_to_uut=0, busy=0, done=0, vec_count=0, timeout counter=0.
- IDLE: rst_uut=1; start -> WAIT_VEC, busy=1, vec_count and timeout count cleared. start outside IDLE is ignored.
- WAIT_VEC: vec_ready=1. On vec_valid&vec_ready: latch vec_data into input_to_uut, latch vec_last -> RST_UUT.
- RST_UUT: rst_uut=1 for exactly RST_CYCLES cycles (down-counter), input_to_uut stable -> RUN.
- RUN: rst_uut=0. Cycle counter starts at 1 on the first RUN cycle and increments each cycle.
  - end_uut=1 in that cycle: capture output_from_uut and count, res_timeout=0 -> RESULT.
  - Else if count==TIMEOUT_CYCLES: res_data=0, res_cycles=TIMEOUT_CYCLES, res_timeout=1, timeout count++ (saturating at 2^32-1) -> RESULT.
  - end_uut and timeout in the same cycle: end_uut wins.
  - end_uut already high on the first RUN cycle: res_cycles=1.
- RESULT: res_valid=1, fields stable until res_ready. On the handshake: vec_count++, rst_uut=1 from the next cycle. If latched last=1 -> DONE, else -> WAIT_VEC.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: from vector accept to first UUT-active cycle is RST_CYCLES+1 cycles.
- input_to_uut is held until the next vector is accepted.
- res_valid never drops without res_ready (AXI-style; no combinational ready->valid path).
- Mid-operation rst: everything returns to reset values immediately; the in-flight vector is lost.

Optional Feature:
UUT_REPEAT_CHECK_EN
- Defined: each vector runs twice (RST_UUT/RUN twice). First output and count are stored. res_mismatch=1 if the second output differs or either run timed out. Reported res_data and res_cycles come from the second run.
- Undefined: single run per vector, res_mismatch tied 0, no storage register.

Decomposition:
- Package uut_test_pkg: state enum (IDLE, WAIT_VEC, RST_UUT, RUN, RESULT, DONE), debug_sel encodings, result record struct {data, cycles, timeout, mismatch, last}.
- Sub-module uut_run_timer: cycle counter with saturation compare against TIMEOUT_CYCLES; outputs count and timeout flag.

Test Plan:
- Single vector, last=1; UUT model raises end_uut after 70 cycles with output 0xDEADBEEF -> one record with res_cycles=70, res_timeout=0, res_data=0xDEADBEEF; done pulses once; vec_count=1.
- Three vectors with res_ready stalled 10 cycles on record 2 -> record fields stable during stall, vec_ready=0 throughout; rst_uut high for RST_CYCLES=4 before each run.
- UUT never ends, TIMEOUT_CYCLES=100 -> res_timeout=1, res_cycles=100, res_data=0; debug_sel=3 reads 1.
- end_uut asserted on first RUN cycle and at cycle TIMEOUT_CYCLES -> res_cycles=1; then for the coincident case, res_timeout=0.
- rst asserted during RUN of vector 2 -> all outputs at reset values the same cycle, rst_uut=1; new start resumes cleanly with vec_count=0.
- With UUT_REPEAT_CHECK_EN and the UUT model returning different outputs per run -> res_mismatch=1; with a consistent model -> res_mismatch=0.
